// File: rtl/csr_file.sv
// Control/status register file: exception entry/return, interrupt status and an optional countdown timer.
// Define CSR_TIMER_EN to build the TCFG/TVAL/TICLR timer and its ESTAT[11] interrupt.
module csr_file #(
    parameter logic [31:0] TID_RESET = 32'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        csr_re,
    input  logic [13:0] csr_num,
    output logic [31:0] csr_rvalue,
    input  logic        csr_we,
    input  logic [31:0] csr_wmask,
    input  logic [31:0] csr_wvalue,
    input  logic        wb_ex,
    input  logic [5:0]  wb_ecode,
    input  logic [8:0]  wb_esubcode,
    input  logic [31:0] wb_ex_pc,
    input  logic [31:0] wb_vaddr,
    input  logic        ertn_flush,
    input  logic [7:0]  hw_int_in,
    input  logic        ipi_int_in,
    output logic        has_int,
    output logic [31:0] ex_entry,
    output logic [31:0] ertn_entry
);

    localparam logic [13:0] CSR_CRMD   = 14'h00;
    localparam logic [13:0] CSR_PRMD   = 14'h01;
    localparam logic [13:0] CSR_ECFG   = 14'h04;
    localparam logic [13:0] CSR_ESTAT  = 14'h05;
    localparam logic [13:0] CSR_ERA    = 14'h06;
    localparam logic [13:0] CSR_BADV   = 14'h07;
    localparam logic [13:0] CSR_EENTRY = 14'h0C;
    localparam logic [13:0] CSR_SAVE0  = 14'h30;
    localparam logic [13:0] CSR_SAVE1  = 14'h31;
    localparam logic [13:0] CSR_SAVE2  = 14'h32;
    localparam logic [13:0] CSR_SAVE3  = 14'h33;
    localparam logic [13:0] CSR_TID    = 14'h40;
    localparam logic [13:0] CSR_TCFG   = 14'h41;
    localparam logic [13:0] CSR_TVAL   = 14'h42;

    localparam logic [5:0] ECODE_ADEF = 6'h08;
    localparam logic [5:0] ECODE_ALE  = 6'h09;

    logic [31:0] crmd, prmd, ecfg, estat, era, badv, eentry, tid;
    logic [31:0] save [4];
    logic        wr_en;

    function automatic logic [31:0] csr_merge(input logic [31:0] old, input logic [31:0] wmask,
                                              input logic [31:0] wvalue, input logic [31:0] writable);
        logic [31:0] m;
        m = wmask & writable;
        return (old & ~m) | (wvalue & m);
    endfunction

    // An exception commit squashes the software write issued alongside it.
    assign wr_en = csr_we & ~wb_ex;

`ifdef CSR_TIMER_EN
    localparam logic [13:0] CSR_TICLR = 14'h44;

    logic [31:0] tcfg, tval, tcfg_new;
    logic        tcfg_wr, timer_fire, ticlr_wr;

    assign tcfg_wr    = wr_en & (csr_num == CSR_TCFG);
    assign tcfg_new   = csr_merge(tcfg, csr_wmask, csr_wvalue, 32'hFFFF_FFFF);
    assign timer_fire = ~tcfg_wr & tcfg[0] & (tval == 32'h0);
    assign ticlr_wr   = wr_en & (csr_num == CSR_TICLR) & csr_wvalue[0] & csr_wmask[0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tcfg <= 32'h0;
            tval <= 32'h0;
        end else if (tcfg_wr) begin
            tcfg <= tcfg_new;
            tval <= {tcfg_new[31:2], 2'b00};
        end else if (tcfg[0]) begin
            if (tval != 32'h0) begin
                tval <= tval - 32'd1;
            end else if (tcfg[1]) begin
                tval <= {tcfg[31:2], 2'b00};
            end else begin
                tcfg[0] <= 1'b0;
            end
        end
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            crmd   <= 32'h8;
            prmd   <= 32'h0;
            ecfg   <= 32'h0;
            estat  <= 32'h0;
            era    <= 32'h0;
            badv   <= 32'h0;
            eentry <= 32'h0;
            tid    <= TID_RESET;
            for (int i = 0; i < 4; i++) begin
                save[i] <= 32'h0;
            end
        end else begin
            if (wr_en) begin
                case (csr_num)
                    CSR_CRMD:   crmd   <= csr_merge(crmd, csr_wmask, csr_wvalue, 32'h0000_0007);
                    CSR_PRMD:   prmd   <= csr_merge(prmd, csr_wmask, csr_wvalue, 32'h0000_0007);
                    CSR_ECFG:   ecfg   <= csr_merge(ecfg, csr_wmask, csr_wvalue, 32'h0000_1BFF);
                    CSR_ESTAT:  estat  <= csr_merge(estat, csr_wmask, csr_wvalue, 32'h0000_0003);
                    CSR_ERA:    era    <= csr_merge(era, csr_wmask, csr_wvalue, 32'hFFFF_FFFF);
                    CSR_BADV:   badv   <= csr_merge(badv, csr_wmask, csr_wvalue, 32'hFFFF_FFFF);
                    CSR_EENTRY: eentry <= csr_merge(eentry, csr_wmask, csr_wvalue, 32'hFFFF_FFC0);
                    CSR_SAVE0, CSR_SAVE1, CSR_SAVE2, CSR_SAVE3:
                        save[csr_num[1:0]] <= csr_merge(save[csr_num[1:0]], csr_wmask, csr_wvalue,
                                                        32'hFFFF_FFFF);
                    CSR_TID:    tid    <= csr_merge(tid, csr_wmask, csr_wvalue, 32'hFFFF_FFFF);
                    default: ;
                endcase
            end

            // Interrupt lines are level samples and override any software write of ESTAT.
            estat[9:2] <= hw_int_in;
            estat[12]  <= ipi_int_in;
`ifdef CSR_TIMER_EN
            if (timer_fire) begin
                estat[11] <= 1'b1;
            end else if (ticlr_wr) begin
                estat[11] <= 1'b0;
            end
`endif

            if (wb_ex) begin
                prmd[2:0]    <= crmd[2:0];
                crmd[2:0]    <= 3'b000;
                era          <= wb_ex_pc;
                estat[21:16] <= wb_ecode;
                estat[30:22] <= wb_esubcode;
                if (wb_ecode == ECODE_ADEF) begin
                    badv <= wb_ex_pc;
                end else if (wb_ecode == ECODE_ALE) begin
                    badv <= wb_vaddr;
                end
            end else if (ertn_flush) begin
                crmd[2:0] <= prmd[2:0];
            end
        end
    end

    always_comb begin
        csr_rvalue = 32'h0;
        if (csr_re) begin
            case (csr_num)
                CSR_CRMD:   csr_rvalue = crmd;
                CSR_PRMD:   csr_rvalue = prmd;
                CSR_ECFG:   csr_rvalue = ecfg;
                CSR_ESTAT:  csr_rvalue = estat;
                CSR_ERA:    csr_rvalue = era;
                CSR_BADV:   csr_rvalue = badv;
                CSR_EENTRY: csr_rvalue = eentry;
                CSR_SAVE0, CSR_SAVE1, CSR_SAVE2, CSR_SAVE3:
                    csr_rvalue = save[csr_num[1:0]];
                CSR_TID:    csr_rvalue = tid;
`ifdef CSR_TIMER_EN
                CSR_TCFG:   csr_rvalue = tcfg;
                CSR_TVAL:   csr_rvalue = tval;
`endif
                default:    csr_rvalue = 32'h0;
            endcase
        end
    end

    assign has_int    = crmd[2] & (|(estat[12:0] & ecfg[12:0]));
    assign ex_entry   = eentry;
    assign ertn_entry = era;

endmodule

// File: tb/tb_csr_file.sv
// Self-checking bench for csr_file: directed scenarios plus randomized traffic against a table-driven model.
// Timer scenarios are selected by CSR_TIMER_EN, matching the build of the design.
`timescale 1ns/1ps
module tb_csr_file;

    localparam logic [31:0] TID_R = 32'h5A5A_0001;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        csr_re = 1'b0;
    logic [13:0] csr_num = 14'h0;
    logic [31:0] csr_rvalue;
    logic        csr_we = 1'b0;
    logic [31:0] csr_wmask = 32'h0;
    logic [31:0] csr_wvalue = 32'h0;
    logic        wb_ex = 1'b0;
    logic [5:0]  wb_ecode = 6'h0;
    logic [8:0]  wb_esubcode = 9'h0;
    logic [31:0] wb_ex_pc = 32'h0;
    logic [31:0] wb_vaddr = 32'h0;
    logic        ertn_flush = 1'b0;
    logic [7:0]  hw_int_in = 8'h0;
    logic        ipi_int_in = 1'b0;
    logic        has_int;
    logic [31:0] ex_entry;
    logic [31:0] ertn_entry;

    int checks = 0;
    int errors = 0;

    // Model state: registers indexed by CSR number, timer value kept separately.
    logic [31:0] mreg [128];
    logic [31:0] m_tval;
    logic [13:0] nums [17] = '{14'h00, 14'h01, 14'h04, 14'h05, 14'h06, 14'h07, 14'h0C, 14'h30,
                               14'h31, 14'h32, 14'h33, 14'h40, 14'h41, 14'h42, 14'h44, 14'h02, 14'h100};

    csr_file #(.TID_RESET(TID_R)) dut (
        .clk(clk), .reset(reset), .csr_re(csr_re), .csr_num(csr_num), .csr_rvalue(csr_rvalue),
        .csr_we(csr_we), .csr_wmask(csr_wmask), .csr_wvalue(csr_wvalue),
        .wb_ex(wb_ex), .wb_ecode(wb_ecode), .wb_esubcode(wb_esubcode), .wb_ex_pc(wb_ex_pc),
        .wb_vaddr(wb_vaddr), .ertn_flush(ertn_flush), .hw_int_in(hw_int_in), .ipi_int_in(ipi_int_in),
        .has_int(has_int), .ex_entry(ex_entry), .ertn_entry(ertn_entry)
    );

    always #50 clk = ~clk;

    function automatic logic [31:0] m_writable(input logic [13:0] n);
        case (n)
            14'h00, 14'h01: return 32'h7;
            14'h04: return 32'h1BFF;
            14'h05: return 32'h3;
            14'h0C: return 32'hFFFF_FFC0;
            14'h06, 14'h07, 14'h30, 14'h31, 14'h32, 14'h33, 14'h40: return 32'hFFFF_FFFF;
`ifdef CSR_TIMER_EN
            14'h41: return 32'hFFFF_FFFF;
`endif
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] m_read(input logic [13:0] n);
        case (n)
            14'h00, 14'h01, 14'h04, 14'h05, 14'h06, 14'h07, 14'h0C,
            14'h30, 14'h31, 14'h32, 14'h33, 14'h40: return mreg[n[6:0]];
`ifdef CSR_TIMER_EN
            14'h41: return mreg[7'h41];
            14'h42: return m_tval;
`endif
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 128; i++) mreg[i] = 32'h0;
        mreg[7'h00] = 32'h8;
        mreg[7'h40] = TID_R;
        m_tval = 32'h0;
    endtask

    // Next state from the architectural rules, evaluated on the inputs about to be clocked.
    task automatic model_tick();
        logic [31:0] o [128];
        logic [31:0] m;
        logic [31:0] ov;
        logic        we;
        logic        fire;
        o = mreg;
        ov = m_tval;
        we = csr_we && !wb_ex;
        fire = 1'b0;
        if (we && csr_num < 14'd128) begin
            m = csr_wmask & m_writable(csr_num);
            mreg[csr_num[6:0]] = (o[csr_num[6:0]] & ~m) | (csr_wvalue & m);
        end
        mreg[7'h05][9:2] = hw_int_in;
        mreg[7'h05][12] = ipi_int_in;
        if (wb_ex) begin
            mreg[7'h01][2:0] = o[7'h00][2:0];
            mreg[7'h00][2:0] = 3'b000;
            mreg[7'h06] = wb_ex_pc;
            mreg[7'h05][21:16] = wb_ecode;
            mreg[7'h05][30:22] = wb_esubcode;
            if (wb_ecode == 6'h08) mreg[7'h07] = wb_ex_pc;
            else if (wb_ecode == 6'h09) mreg[7'h07] = wb_vaddr;
        end else if (ertn_flush) begin
            mreg[7'h00][2:0] = o[7'h01][2:0];
        end
`ifdef CSR_TIMER_EN
        if (we && csr_num == 14'h41) begin
            m_tval = {mreg[7'h41][31:2], 2'b00};
        end else if (o[7'h41][0]) begin
            if (ov != 32'h0) m_tval = ov - 32'd1;
            else begin
                fire = 1'b1;
                if (o[7'h41][1]) m_tval = {o[7'h41][31:2], 2'b00};
                else mreg[7'h41][0] = 1'b0;
            end
        end
        if (fire) mreg[7'h05][11] = 1'b1;
        else if (we && csr_num == 14'h44 && csr_wvalue[0] && csr_wmask[0]) mreg[7'h05][11] = 1'b0;
`endif
    endtask

    task automatic cycle();
        model_tick();
        @(posedge clk);
        #1;
        csr_we = 1'b0;
        wb_ex = 1'b0;
        ertn_flush = 1'b0;
    endtask

    task automatic wr(input logic [13:0] n, input logic [31:0] m, input logic [31:0] v);
        csr_we = 1'b1; csr_num = n; csr_wmask = m; csr_wvalue = v;
        cycle();
    endtask

    task automatic rd(input logic [13:0] n, output logic [31:0] v);
        csr_re = 1'b1; csr_num = n;
        #1;
        v = csr_rvalue;
        csr_re = 1'b0;
    endtask

    task automatic assert_reset();
        reset = 1'b1;
        model_reset();
        #1;
    endtask

    task automatic release_reset();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic do_reset();
        hw_int_in = 8'h0; ipi_int_in = 1'b0;
        assert_reset();
        release_reset();
    endtask

    task automatic test_reset();
        logic [31:0] v, e;
        do_reset();
        for (int i = 0; i < 17; i++) begin
            rd(nums[i], v);
            e = (nums[i] == 14'h00) ? 32'h8 : (nums[i] == 14'h40) ? TID_R : 32'h0;
            checks++; if (v !== e) begin errors++; $display("FAIL reset_rd num=%h got %h exp %h", nums[i], v, e); end
        end
        checks++; if ({has_int, ex_entry, ertn_entry} !== 65'h0) begin errors++; $display("FAIL reset_outs got %b/%h/%h exp 0", has_int, ex_entry, ertn_entry); end
        wr(14'h30, 32'hFFFF_FFFF, 32'hA5A5_5A5A);
        csr_num = 14'h30; csr_re = 1'b0; #1;
        checks++; if (csr_rvalue !== 32'h0) begin errors++; $display("FAIL re_low got %h exp 0", csr_rvalue); end
        rd(14'h30, v);
        checks++; if (v !== 32'hA5A5_5A5A) begin errors++; $display("FAIL save0_wr got %h exp a5a55a5a", v); end
        assert_reset();
        rd(14'h30, v);
        checks++; if (v !== 32'h0) begin errors++; $display("FAIL async_reset got %h exp 0", v); end
        release_reset();
    endtask

    task automatic test_write_masks();
        logic [31:0] v;
        do_reset();
        wr(14'h00, 32'hFFFF_FFFF, 32'h7);
        rd(14'h00, v); checks++; if (v !== 32'hF) begin errors++; $display("FAIL crmd_w7 got %h exp f", v); end
        wr(14'h00, 32'hFFFF_FFFF, 32'hFFFF_FFF0);
        rd(14'h00, v); checks++; if (v !== 32'h8) begin errors++; $display("FAIL crmd_da got %h exp 8", v); end
        wr(14'h00, 32'h1, 32'h7);
        rd(14'h00, v); checks++; if (v !== 32'h9) begin errors++; $display("FAIL crmd_mask got %h exp 9", v); end
        wr(14'h04, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        rd(14'h04, v); checks++; if (v !== 32'h1BFF) begin errors++; $display("FAIL ecfg_ro got %h exp 1bff", v); end
        wr(14'h0C, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        rd(14'h0C, v); checks++; if (v !== 32'hFFFF_FFC0 || ex_entry !== 32'hFFFF_FFC0) begin errors++; $display("FAIL eentry got %h/%h exp ffffffc0", v, ex_entry); end
        wr(14'h05, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        rd(14'h05, v); checks++; if (v !== 32'h3) begin errors++; $display("FAIL estat_ro got %h exp 3", v); end
        wr(14'h40, 32'hFFFF_0000, 32'h1234_5678);
        rd(14'h40, v); checks++; if (v !== 32'h1234_0001) begin errors++; $display("FAIL tid_mask got %h exp 12340001", v); end
        hw_int_in = 8'hA5; ipi_int_in = 1'b1;
        cycle();
        rd(14'h05, v); checks++; if (v !== 32'h1297) begin errors++; $display("FAIL estat_irq got %h exp 1297", v); end
        hw_int_in = 8'h0; ipi_int_in = 1'b0;
        cycle();
    endtask

    task automatic test_exception();
        logic [31:0] v;
        do_reset();
        wr(14'h00, 32'hFFFF_FFFF, 32'h7);
        wb_ex = 1'b1; wb_ecode = 6'h08; wb_esubcode = 9'h0; wb_ex_pc = 32'h1C00_0100; wb_vaddr = 32'hDEAD_BEEF;
        cycle();
        rd(14'h00, v); checks++; if (v !== 32'h8) begin errors++; $display("FAIL ex_crmd got %h exp 8", v); end
        rd(14'h01, v); checks++; if (v !== 32'h7) begin errors++; $display("FAIL ex_prmd got %h exp 7", v); end
        rd(14'h06, v); checks++; if (v !== 32'h1C00_0100 || ertn_entry !== 32'h1C00_0100) begin errors++; $display("FAIL ex_era got %h/%h exp 1c000100", v, ertn_entry); end
        rd(14'h07, v); checks++; if (v !== 32'h1C00_0100) begin errors++; $display("FAIL ex_badv_adef got %h exp 1c000100", v); end
        rd(14'h05, v); checks++; if (v !== 32'h0008_0000) begin errors++; $display("FAIL ex_estat got %h exp 00080000", v); end
        ertn_flush = 1'b1;
        cycle();
        rd(14'h00, v); checks++; if (v !== 32'hF) begin errors++; $display("FAIL ertn_crmd got %h exp f", v); end
        ertn_flush = 1'b1; wb_ex = 1'b1; wb_ecode = 6'h09; wb_esubcode = 9'h1A5;
        wb_ex_pc = 32'h1C00_0200; wb_vaddr = 32'h1234_5678;
        cycle();
        rd(14'h00, v); checks++; if (v !== 32'h8) begin errors++; $display("FAIL exertn_crmd got %h exp 8", v); end
        rd(14'h01, v); checks++; if (v !== 32'h7) begin errors++; $display("FAIL exertn_prmd got %h exp 7", v); end
        rd(14'h07, v); checks++; if (v !== 32'h1234_5678) begin errors++; $display("FAIL ex_badv_ale got %h exp 12345678", v); end
        rd(14'h05, v); checks++; if (v !== 32'h6949_0000) begin errors++; $display("FAIL ex_estat_sub got %h exp 69490000", v); end
        wr(14'h30, 32'hFFFF_FFFF, 32'h1111_1111);
        csr_we = 1'b1; csr_num = 14'h30; csr_wmask = 32'hFFFF_FFFF; csr_wvalue = 32'h2222_2222;
        wb_ex = 1'b1; wb_ecode = 6'h0B; wb_esubcode = 9'h0; wb_ex_pc = 32'h1C00_0300; wb_vaddr = 32'h0;
        cycle();
        rd(14'h30, v); checks++; if (v !== 32'h1111_1111) begin errors++; $display("FAIL save0_exblock got %h exp 11111111", v); end
        rd(14'h07, v); checks++; if (v !== 32'h1234_5678) begin errors++; $display("FAIL badv_hold got %h exp 12345678", v); end
        rd(14'h06, v); checks++; if (v !== 32'h1C00_0300) begin errors++; $display("FAIL era_syscall got %h exp 1c000300", v); end
    endtask

    task automatic test_has_int_sw();
        do_reset();
        wr(14'h05, 32'h1, 32'h1);
        wr(14'h04, 32'hFFFF_FFFF, 32'h1);
        checks++; if (has_int !== 1'b0) begin errors++; $display("FAIL swint_ie0 got %b exp 0", has_int); end
        wr(14'h00, 32'hFFFF_FFFF, 32'h4);
        checks++; if (has_int !== 1'b1) begin errors++; $display("FAIL swint_ie1 got %b exp 1", has_int); end
        wr(14'h04, 32'hFFFF_FFFF, 32'h2);
        checks++; if (has_int !== 1'b0) begin errors++; $display("FAIL swint_masked got %b exp 0", has_int); end
    endtask

`ifdef CSR_TIMER_EN
    task automatic test_timer();
        logic [31:0] v, s;
        do_reset();
        wr(14'h41, 32'hFFFF_FFFF, 32'hF);
        rd(14'h42, v); checks++; if (v !== 32'd12) begin errors++; $display("FAIL tval_load got %0d exp 12", v); end
        for (int i = 11; i >= 0; i--) begin
            cycle();
            rd(14'h42, v); checks++; if (v !== i) begin errors++; $display("FAIL tval_count got %0d exp %0d", v, i); end
        end
        cycle();
        rd(14'h42, v); rd(14'h05, s);
        checks++; if (v !== 32'd12 || s[11] !== 1'b1) begin errors++; $display("FAIL timer_expire got tval=%0d ti=%b exp 12/1", v, s[11]); end
        wr(14'h44, 32'h1, 32'h1);
        rd(14'h42, v); rd(14'h05, s);
        checks++; if (v !== 32'd11 || s[11] !== 1'b0) begin errors++; $display("FAIL ticlr got tval=%0d ti=%b exp 11/0", v, s[11]); end
        repeat (11) cycle();
        wr(14'h44, 32'h1, 32'h1);
        rd(14'h42, v); rd(14'h05, s);
        checks++; if (v !== 32'd12 || s[11] !== 1'b1) begin errors++; $display("FAIL ticlr_vs_expire got tval=%0d ti=%b exp 12/1", v, s[11]); end
        wr(14'h04, 32'hFFFF_FFFF, 32'h800);
        wr(14'h00, 32'hFFFF_FFFF, 32'h4);
        checks++; if (has_int !== 1'b1) begin errors++; $display("FAIL timer_int got %b exp 1", has_int); end
        wr(14'h00, 32'hFFFF_FFFF, 32'h0);
        checks++; if (has_int !== 1'b0) begin errors++; $display("FAIL timer_int_ie0 got %b exp 0", has_int); end
        wr(14'h41, 32'hFFFF_FFFF, 32'h5);
        repeat (4) cycle();
        rd(14'h42, v); checks++; if (v !== 32'd0) begin errors++; $display("FAIL oneshot_zero got %0d exp 0", v); end
        wr(14'h44, 32'h1, 32'h1);
        cycle();
        rd(14'h05, s); rd(14'h41, v);
        checks++; if (s[11] !== 1'b1 || v !== 32'h4) begin errors++; $display("FAIL oneshot_expire got ti=%b tcfg=%h exp 1/4", s[11], v); end
        cycle();
        rd(14'h42, v); checks++; if (v !== 32'd0) begin errors++; $display("FAIL oneshot_hold got %0d exp 0", v); end
        wr(14'h41, 32'hFFFF_FFFF, 32'h11);
        repeat (5) cycle();
        rd(14'h42, v); checks++; if (v !== 32'd11) begin errors++; $display("FAIL tval_midrun got %0d exp 11", v); end
        assert_reset();
        rd(14'h42, v); rd(14'h41, s);
        checks++; if (v !== 32'h0 || s !== 32'h0) begin errors++; $display("FAIL timer_reset got tval=%h tcfg=%h exp 0/0", v, s); end
        release_reset();
        repeat (20) cycle();
        rd(14'h42, v); rd(14'h05, s);
        checks++; if (v !== 32'h0 || s[11] !== 1'b0) begin errors++; $display("FAIL timer_abort got tval=%h ti=%b exp 0/0", v, s[11]); end
    endtask
`else
    task automatic test_timer_disabled();
        logic [31:0] v, s;
        do_reset();
        wr(14'h41, 32'hFFFF_FFFF, 32'hF);
        rd(14'h41, v); rd(14'h42, s);
        checks++; if (v !== 32'h0 || s !== 32'h0) begin errors++; $display("FAIL notimer_regs got tcfg=%h tval=%h exp 0/0", v, s); end
        wr(14'h04, 32'hFFFF_FFFF, 32'h800);
        wr(14'h00, 32'hFFFF_FFFF, 32'h4);
        repeat (20) cycle();
        rd(14'h05, s);
        checks++; if (s[11] !== 1'b0 || has_int !== 1'b0) begin errors++; $display("FAIL notimer_int got ti=%b has_int=%b exp 0/0", s[11], has_int); end
    endtask
`endif

    task automatic test_random();
        logic [31:0] v, e;
        do_reset();
        for (int c = 0; c < 300; c++) begin
            csr_num = nums[$urandom_range(0, 16)];
            csr_we = ($urandom_range(0, 1) == 1);
            csr_wmask = ($urandom_range(0, 3) == 0) ? $urandom : 32'hFFFF_FFFF;
            csr_wvalue = (csr_num == 14'h41) ? 32'($urandom_range(0, 63)) : $urandom;
            wb_ex = ($urandom_range(0, 9) == 0);
            wb_ecode = ($urandom_range(0, 2) == 0) ? 6'h08 : ($urandom_range(0, 1) == 0) ? 6'h09 : 6'($urandom);
            wb_esubcode = 9'($urandom);
            wb_ex_pc = $urandom;
            wb_vaddr = $urandom;
            ertn_flush = ($urandom_range(0, 9) == 0);
            hw_int_in = 8'($urandom);
            ipi_int_in = 1'($urandom);
            if (ertn_flush && csr_we && csr_num == 14'h00) ertn_flush = 1'b0;
`ifdef CSR_TIMER_EN
            if (csr_we && csr_num == 14'h41 && mreg[7'h41][0] && m_tval == 32'h0) csr_we = 1'b0;
`endif
            cycle();
            for (int i = 0; i < 17; i++) begin
                rd(nums[i], v);
                e = m_read(nums[i]);
                checks++; if (v !== e) begin errors++; $display("FAIL rand_rd cyc=%0d num=%h got %h exp %h", c, nums[i], v, e); end
            end
            e = {31'h0, mreg[7'h00][2] & (|(mreg[7'h05][12:0] & mreg[7'h04][12:0]))};
            checks++; if ({31'h0, has_int} !== e) begin errors++; $display("FAIL rand_has_int cyc=%0d got %b exp %b", c, has_int, e[0]); end
            checks++; if (ex_entry !== mreg[7'h0C] || ertn_entry !== mreg[7'h06]) begin errors++; $display("FAIL rand_entry cyc=%0d got %h/%h exp %h/%h", c, ex_entry, ertn_entry, mreg[7'h0C], mreg[7'h06]); end
        end
        hw_int_in = 8'h0; ipi_int_in = 1'b0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_write_masks();
        test_exception();
        test_has_int_sw();
`ifdef CSR_TIMER_EN
        test_timer();
`else
        test_timer_disabled();
`endif
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/csr_file.md
CSR_FILE -- requirements
Module: csr_file

Interface
REQ-001 SHALL provide parameter TID_RESET, default 32'h0, reset value of TID.
REQ-002 SHALL provide port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL provide port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL provide ports csr_re input 1 read enable; csr_num input 14 register number; csr_rvalue output 32 read data.
REQ-005 SHALL provide ports csr_we input 1, csr_wmask input 32, csr_wvalue input 32; write strobe, bit mask, data.
REQ-006 SHALL provide ports wb_ex input 1, wb_ecode input 6, wb_esubcode input 9, wb_ex_pc input 32, wb_vaddr input 32; exception commit from the writeback stage.
REQ-007 SHALL provide port ertn_flush  input  1  ertn commit.
REQ-008 SHALL provide ports hw_int_in input 8 and ipi_int_in input 1; level interrupt sources.
REQ-009 SHALL provide outputs has_int 1, ex_entry 32, ertn_entry 32.

Function
REQ-010 SHALL decode CRMD 0x0, PRMD 0x1, ECFG 0x4, ESTAT 0x5, ERA 0x6, BADV 0x7, EENTRY 0xC, SAVE0-3 0x30-0x33, TID 0x40, TCFG 0x41, TVAL 0x42, TICLR 0x44.
REQ-011 SHALL return csr_rvalue combinationally from csr_num: current register value, 0 for undecoded numbers and TICLR, 0 when csr_re=0.
REQ-012 SHALL apply each write as new = (old & ~wmask) | (wvalue & wmask), restricted to the writable bits below, visible on reads from the next cycle.
REQ-013 SHALL make writable: CRMD[2:0] (PLV, IE), PRMD[2:0], ECFG bits 12:11 and 9:0, ESTAT[1:0], ERA, BADV, EENTRY[31:6], SAVE0-3, TID, TCFG; all other bits read-only.
REQ-014 SHALL ignore csr_we in any cycle with wb_ex=1.
REQ-015 SHALL on wb_ex: PRMD.PPLV<=CRMD.PLV, PRMD.PIE<=CRMD.IE, CRMD.PLV<=0, CRMD.IE<=0, ERA<=wb_ex_pc, ESTAT[21:16]<=wb_ecode, ESTAT[30:22]<=wb_esubcode.
REQ-016 SHALL on wb_ex load BADV<=wb_ex_pc if wb_ecode=0x8 (ADEF), BADV<=wb_vaddr if 0x9 (ALE), else hold BADV.
REQ-017 SHALL on ertn_flush (wb_ex=0): CRMD.PLV<=PRMD.PPLV, CRMD.IE<=PRMD.PIE; wb_ex wins if both asserted.
REQ-018 SHALL sample ESTAT[9:2]<=hw_int_in and ESTAT[12]<=ipi_int_in every cycle.
REQ-019 SHALL drive has_int = CRMD.IE & |(ESTAT[12:0] & ECFG[12:0]), combinationally.
REQ-020 SHALL drive ex_entry = EENTRY and ertn_entry = ERA, combinationally.
REQ-021 SHALL, on a TCFG write, load TVAL<={new InitVal,2'b00} in the same edge; TCFG fields En[0], Periodic[1], InitVal[31:2].
REQ-022 SHALL, while En=1 and TVAL!=0 (no TCFG write), decrement TVAL by 1 per cycle.
REQ-023 SHALL, when En=1 and TVAL=0: set ESTAT[11]; if Periodic=1 reload TVAL<={InitVal,2'b00}, else clear En and hold TVAL=0.
REQ-024 SHALL clear ESTAT[11] on a TICLR write with wvalue[0]&wmask[0]=1; a timer expiry in the same cycle wins (ESTAT[11] stays 1).

Reset
REQ-025 SHALL on reset set CRMD=32'h8 (DA=1), TID=TID_RESET, all other registers and TVAL to 0, ESTAT[11]=0.
REQ-026 SHALL abort any timer countdown on reset; counting resumes only after a new TCFG write with En=1.

Configuration
REQ-027 SHALL implement TCFG/TVAL/TICLR and ESTAT[11] (REQ-021..024) only when CSR_TIMER_EN is defined.
REQ-028 SHALL without CSR_TIMER_EN read TCFG, TVAL as 0, ignore their writes, and hold ESTAT[11]=0.

Verification
REQ-029 SHALL check: write CRMD wmask=0xFFFFFFFF wvalue=0x7 -> next-cycle read CRMD=0xF; DA bit unaffected by writes.
REQ-030 SHALL check: CRMD=0x7, wb_ex=1 ecode=0x8 pc=0x1C000100 -> CRMD=0x8, PRMD=0x7, ERA=0x1C000100, BADV=0x1C000100, ESTAT[21:16]=0x8.
REQ-031 SHALL check: after REQ-030, ertn_flush=1 -> CRMD[2:0]=0x7; ertn_flush with wb_ex=1 -> wb_ex effect only.
REQ-032 SHALL check: TCFG=0x0000000F (InitVal=3, periodic) -> TVAL 12,11..0, ESTAT[11]=1 at expiry, TVAL reloads 12; TICLR write 0x1 same cycle as expiry -> ESTAT[11] remains 1.
REQ-033 SHALL check: ECFG=0x800, CRMD.IE=1, timer expiry -> has_int=1; CRMD.IE=0 -> has_int=0; csr_we with wb_ex=1 to SAVE0 -> SAVE0 unchanged.
